// File: rtl/neuron.sv
// ---------------------------------------------------------------------------
// neuron
//
// Pipelined fixed-point artificial neuron. The datapath multiplies N signed
// inputs by N signed weights, adds a signed bias, saturates the sum to W bits
// and applies a ReLU. New operands are accepted on every cycle. The result
// appears on the output three rising edges after the operands are sampled.
//
// Every word uses signed two's-complement Q(W-FRAC).FRAC format.
//
// Ports:
//   clk      - single clock; all state updates on the rising edge
//   rst_n    - synchronous active-low clear of every pipeline register
//   in       - packed inputs,  x[i] = in[i*W +: W]
//   constant - packed weights, w[i] = constant[i*W +: W];
//              bias b = constant[N*W +: W]
//   out      - registered neuron output, never negative
//
// Pipeline:
//   stage 1 : N full-width products, each shifted right by FRAC; bias
//   stage 2 : four partial sums of the shifted products; bias
//   stage 3 : final add, saturation and ReLU, registered into out
// ---------------------------------------------------------------------------
module neuron #(
    parameter int N    = 32,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     in,
    input  logic [(N+1)*W-1:0] constant,
    output logic [W-1:0]       out
);

    // A full product needs 2W bits. After the FRAC shift, 2W-FRAC bits are
    // enough. The accumulator adds headroom for N products plus the bias
    // and one guard bit. This guarantees that no intermediate sum can wrap.
    localparam int PROD_W     = 2 * W;
    localparam int SHIFT_W    = 2 * W - FRAC;
    localparam int ACC_W      = 2 * W - FRAC + $clog2(N + 1) + 1;
    localparam int NUM_GROUPS = 4;
    localparam int GROUP_SIZE = (N + NUM_GROUPS - 1) / NUM_GROUPS;

    // These are the most positive and most negative W-bit values,
    // sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};

    localparam logic [W-1:0] OUT_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] OUT_MIN = {1'b1, {(W - 1){1'b0}}};

    // -----------------------------------------------------------------------
    // Stage 1 signals
    // -----------------------------------------------------------------------
    logic signed [PROD_W-1:0]  full_prod [N];
    logic signed [SHIFT_W-1:0] prod_d    [N];
    logic signed [SHIFT_W-1:0] prod_q    [N];
    logic        [W-1:0]       bias1_d;
    logic        [W-1:0]       bias1_q;

    // -----------------------------------------------------------------------
    // Stage 2 signals
    // -----------------------------------------------------------------------
    logic signed [ACC_W-1:0]   group_d   [NUM_GROUPS];
    logic signed [ACC_W-1:0]   group_q   [NUM_GROUPS];
    logic        [W-1:0]       bias2_d;
    logic        [W-1:0]       bias2_q;

    // -----------------------------------------------------------------------
    // Stage 3 signals
    // -----------------------------------------------------------------------
    logic signed [ACC_W-1:0]   total;
    logic        [W-1:0]       sat_val;
    logic        [W-1:0]       out_d;
    logic        [W-1:0]       out_q;

    // Form each product from both operands, sign-extended to 2W bits, so
    // the product is exact. The arithmetic shift floors toward minus
    // infinity. After the shift the value always fits in SHIFT_W bits, so
    // the truncating cast only removes redundant sign bits.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            full_prod[i] = PROD_W'($signed(in[i*W +: W]))
                         * PROD_W'($signed(constant[i*W +: W]));
            prod_d[i]    = SHIFT_W'(full_prod[i] >>> FRAC);
        end
        bias1_d = constant[N*W +: W];
    end

    // Stage 1 register: shifted products and bias. Reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                prod_q[i] <= '0;
            end
            bias1_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                prod_q[i] <= prod_d[i];
            end
            bias1_q <= bias1_d;
        end
    end

    // Split the products into four groups and form a partial sum for each.
    // This keeps the adder depth per stage bounded. Lanes past N, which
    // exist only when N is not a multiple of four, contribute nothing.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_d[g] = '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                if (g * GROUP_SIZE + k < N) begin
                    group_d[g] = group_d[g]
                               + ACC_W'(prod_q[g * GROUP_SIZE + k]);
                end
            end
        end
        bias2_d = bias1_q;
    end

    // Stage 2 register: partial sums and bias. Reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                group_q[g] <= '0;
            end
            bias2_q <= '0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                group_q[g] <= group_d[g];
            end
            bias2_q <= bias2_d;
        end
    end

    // Final add: the sign-extended bias plus all partial sums. The result
    // is clamped to the W-bit signed range. Any negative value becomes
    // zero, which includes a negative saturation.
    always_comb begin
        total = ACC_W'($signed(bias2_q));
        for (int g = 0; g < NUM_GROUPS; g++) begin
            total = total + group_q[g];
        end

        if (total > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (total < SAT_MIN) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = total[W-1:0];
        end

        out_d = sat_val[W-1] ? '0 : sat_val;
    end

    // Stage 3 register: the output word. Reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_neuron.sv
// ---------------------------------------------------------------------------
// tb_neuron
//
// Self-checking bench for neuron.
//
// A behavioural model computes each expected result directly from the
// neuron's arithmetic rules, using 64-bit integer math. It applies the floor
// shift, exact sum, saturation and ReLU. A three-deep queue of expected
// words stands for the fixed output latency. Reset empties the queue to
// zeros.
//
// The bench first runs the directed vectors, and their expected values are
// written out as literal constants. It then runs a randomized stream with
// occasional resets, checked against the model.
// ---------------------------------------------------------------------------
module tb_neuron;

    localparam int N    = 32;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic               clk;
    logic               rst_n;
    logic [N*W-1:0]     in_vec;
    logic [(N+1)*W-1:0] const_vec;
    logic [W-1:0]       out;

    int num_checks;
    int num_fail;

    // exp_pipe[2] is the value expected on out after the current edge.
    logic [W-1:0] exp_pipe [3];

    neuron #(
        .N    (N),
        .W    (W),
        .FRAC (FRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_vec),
        .constant (const_vec),
        .out      (out)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference neuron evaluated with plain integer arithmetic.
    function automatic logic [W-1:0] refNeuron(input logic [N*W-1:0] in_v,
                                               input logic [(N+1)*W-1:0] c_v);
        longint acc;
        longint x;
        longint w;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            x   = longint'($signed(in_v[i*W +: W]));
            w   = longint'($signed(c_v[i*W +: W]));
            acc = acc + ((x * w) >>> FRAC);
        end
        acc = acc + longint'($signed(c_v[N*W +: W]));
        if (acc > 64'sd2147483647) begin
            return 32'h7FFF_FFFF;
        end else if (acc < 0) begin
            return 32'h0000_0000;
        end else begin
            return 32'(acc);
        end
    endfunction

    function automatic logic [N*W-1:0] splatIn(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [(N+1)*W-1:0] splatConst(input logic [W-1:0] w,
                                                      input logic [W-1:0] b);
        logic [(N+1)*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = w;
        r[N*W +: W] = b;
        return r;
    endfunction

    // Drive operands and reset. This is called only after a falling edge.
    task automatic applyStimulus(input logic [N*W-1:0] in_v,
                                 input logic [(N+1)*W-1:0] c_v,
                                 input logic rst_v);
        in_vec    = in_v;
        const_vec = c_v;
        rst_n     = rst_v;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: out=%h expected=%h", tag, actual, expected);
        end
    endtask

    // One clock: update the latency model at the rising edge, then compare
    // the output against the model at the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            exp_pipe[0] = '0;
            exp_pipe[1] = '0;
            exp_pipe[2] = '0;
        end else begin
            exp_pipe[2] = exp_pipe[1];
            exp_pipe[1] = exp_pipe[0];
            exp_pipe[0] = refNeuron(in_vec, const_vec);
        end
        @(negedge clk);
        checkOutput(tag, out, exp_pipe[2]);
    endtask

    // Present one operand set for three clocks. Then check the settled
    // output against a hand-derived constant.
    task automatic runDirected(input string tag, input logic [N*W-1:0] in_v,
                               input logic [(N+1)*W-1:0] c_v,
                               input logic [W-1:0] expected);
        applyStimulus(in_v, c_v, 1'b1);
        step(tag);
        step(tag);
        step(tag);
        checkOutput({tag, "_const"}, out, expected);
    endtask

    function automatic logic [W-1:0] randWord();
        case ($urandom_range(0, 3))
            0:       return W'($urandom);
            1:       return W'(int'($urandom_range(0, 2**21)) - 2**20);
            2:       return W'(int'($urandom_range(0, 2**17)) - 2**16);
            default: return W'($urandom_range(0, 8));
        endcase
    endfunction

    logic [N*W-1:0]     tmp_in;
    logic [(N+1)*W-1:0] tmp_c;

    initial begin
        num_checks  = 0;
        num_fail    = 0;
        exp_pipe[0] = '0;
        exp_pipe[1] = '0;
        exp_pipe[2] = '0;

        // Reset is held low for two edges while the operands are arbitrary.
        for (int i = 0; i < N; i++) tmp_in[i*W +: W] = W'($urandom);
        for (int i = 0; i <= N; i++) tmp_c[i*W +: W] = W'($urandom);
        applyStimulus(tmp_in, tmp_c, 1'b0);
        step("reset0");
        checkOutput("reset0_const", out, 32'h0);
        step("reset1");
        checkOutput("reset1_const", out, 32'h0);

        // After release, the output stays zero for two edges. The bias-only
        // result appears on the third edge.
        applyStimulus(splatIn(32'h0), splatConst(32'h8, 32'h8), 1'b1);
        step("release_r");
        checkOutput("release_r_const", out, 32'h0);
        step("release_r1");
        checkOutput("release_r1_const", out, 32'h0);
        step("release_r2");
        checkOutput("bias_only_const", out, 32'h0000_0008);

        // Two vectors on back-to-back cycles produce two consecutive outputs.
        applyStimulus(splatIn(32'h3FFF_FFFF), splatConst(32'h8, 32'h8), 1'b1);
        step("stream_a");
        applyStimulus(splatIn(32'h7FFF_FFFE), splatConst(32'h8, 32'h8), 1'b1);
        step("stream_b");
        step("stream_c");
        checkOutput("stream_first_const", out, 32'h003F_FFE8);
        step("stream_d");
        checkOutput("stream_second_const", out, 32'h007F_FFE8);

        runDirected("neg_floor", splatIn(32'hBFFF_FFFD), splatConst(32'h8, 32'h8), 32'h0);
        runDirected("neg_small", splatIn(32'hFFFF_FFFC), splatConst(32'h8, 32'h8), 32'h0);
        runDirected("sat_pos", splatIn(32'h7FFF_FFFF),
                    splatConst(32'h7FFF_FFFF, 32'h0), 32'h7FFF_FFFF);
        runDirected("sat_neg", splatIn(32'h7FFF_FFFF),
                    splatConst(32'h8000_0000, 32'h0), 32'h0);

        // Single-lane tests check the packing of lanes and of the bias word.
        tmp_in = '0; tmp_c = '0;
        tmp_in[5*W +: W] = 32'h0002_0000;
        tmp_c[5*W +: W]  = 32'h0001_8000;
        tmp_c[N*W +: W]  = 32'h0000_8000;
        runDirected("lane5", tmp_in, tmp_c, 32'h0003_8000);

        tmp_in = '0; tmp_c = '0;
        tmp_in[31*W +: W] = 32'h0002_0000;
        tmp_c[31*W +: W]  = 32'h0001_8000;
        tmp_c[N*W +: W]   = 32'h0000_8000;
        runDirected("lane31", tmp_in, tmp_c, 32'h0003_8000);

        tmp_in = '0; tmp_c = '0;
        tmp_in[5*W +: W] = 32'h0002_0000;
        tmp_c[6*W +: W]  = 32'h0001_8000;
        tmp_c[N*W +: W]  = 32'h0000_8000;
        runDirected("lane_misaligned", tmp_in, tmp_c, 32'h0000_8000);

        tmp_in = '0; tmp_c = '0;
        tmp_c[N*W +: W] = 32'h0003_8000;
        runDirected("bias_word", tmp_in, tmp_c, 32'h0003_8000);

        // A reset during operation discards the results still in flight.
        applyStimulus(splatIn(32'h0001_0000), splatConst(32'h0001_0000, 32'h0), 1'b1);
        step("flush_a");
        step("flush_b");
        applyStimulus(splatIn(32'h0001_0000), splatConst(32'h0001_0000, 32'h0), 1'b0);
        step("flush_rst");
        checkOutput("flush_rst_const", out, 32'h0);
        applyStimulus(splatIn(32'h0001_0000), splatConst(32'h0001_0000, 32'h0), 1'b1);
        step("flush_r");
        checkOutput("flush_r_const", out, 32'h0);
        step("flush_r1");
        checkOutput("flush_r1_const", out, 32'h0);
        step("flush_r2");
        checkOutput("flush_r2_const", out, 32'h0020_0000);

        // Randomized stream with occasional resets, checked against the model.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) tmp_in[i*W +: W] = randWord();
            for (int i = 0; i <= N; i++) tmp_c[i*W +: W] = randWord();
            applyStimulus(tmp_in, tmp_c, ($urandom_range(0, 31) != 0));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_fail);
        $finish;
    end

endmodule
